fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Fetch stage of the 5-stage pipeline. Owns the PC, reads 16-bit instruction words from instruction memory and assembles one- or two-word instructions (opcode plus 16-bit immediate).
- Drives the IF/ID pipeline register consumed by decode.
- Honours the decode hazard unit's active-low enable (load-use stall) and redirects from jump and PC-pop.
- Loads its start PC from the reset vector in M[0], M[1].

Parameters:
- PC_W, 32, PC and address width
- INSTR_W, 16, instruction-memory word width
- RESET_VEC_ADDR, 0, address of the high reset-vector word; the low word is at +1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_use_case_enable  in  1  from hazard unit; 0 = stall fetch and IF/ID, 1 = advance
- jmp_taken  in  1  taken jump/branch resolved downstream
- jmp_target  in  PC_W  jump destination
- ret_pc_valid  in  1  PC popped from stack (RET/RTI) is available
- ret_pc  in  PC_W  popped PC
- imem_addr  out  PC_W  instruction-memory address; combinational read
- imem_data  in  INSTR_W  word at imem_addr, same cycle
- if_id_instr  out  INSTR_W  instruction to decode
- if_id_imm  out  INSTR_W  immediate word; 0 for one-word instructions
- if_id_pc  out  PC_W  address of the instruction's first word
- if_id_valid  out  1  0 = bubble (if_id_instr = 0, NOP)

Behaviour:
- FSM states: VEC_HI, VEC_LO, FETCH, FETCH_IMM. Registers: pc, state, first_word, first_pc, and the IF/ID outputs.
- Reset (rst=1 at edge):
  - state=VEC_HI, pc=0.
  - All if_id_* outputs = 0, including if_id_valid=0.
  - rst mid-operation discards any partial two-word fetch.
- imem_addr:
  - RESET_VEC_ADDR in VEC_HI; RESET_VEC_ADDR+1 in VEC_LO; pc otherwise.
- VEC_HI: pc[31:16] <= imem_data; go to VEC_LO.
- VEC_LO: pc[15:0] <= imem_data; go to FETCH.
- Stall and redirect inputs are ignored in both vector states. IF/ID stays a bubble.
- Two-word test: imem_data[15:13] == TWO_WORD_OP (3'b110).
- FETCH, one-word instruction (advance):
  - IF/ID <= {instr=imem_data, imm=0, pc=pc, valid=1}.
  - pc <= pc+1.
- FETCH, two-word instruction (advance):
  - first_word <= imem_data, first_pc <= pc, pc <= pc+1.
  - IF/ID <= bubble; go to FETCH_IMM.
- FETCH_IMM (advance):
  - IF/ID <= {first_word, imm=imem_data, first_pc, valid=1}.
  - pc <= pc+1; go to FETCH.
- Priority at each edge: rst > ret_pc_valid > jmp_taken > stall (load_use_case_enable=0) > advance.
- Redirect (ret_pc_valid or jmp_taken):
  - pc <= ret_pc or jmp_target respectively.
  - state <= FETCH; IF/ID <= bubble.
  - A pending FETCH_IMM is aborted.
  - Redirect overrides a concurrent stall.
- Stall: pc, state, first_word, first_pc and all IF/ID outputs hold their values.
- Latency:
  - One-word instruction: appears in IF/ID 1 cycle after its address is on imem_addr.
  - Two-word instruction: appears 2 cycles after, with one bubble inserted between it and the preceding instruction.
- PC arithmetic is modulo 2^PC_W; 0xFFFFFFFF+1 wraps to 0.
- No combinational path from inputs to if_id_* outputs. imem_addr depends only on registered state.

Decomposition:
- Shared package (pipeline_pkg), holding:
  - fetch state enum;
  - TWO_WORD_OP and its opcode field position [15:13];
  - NOP encoding (16'h0000);
  - IF/ID bundle typedef (instr, imm, pc, valid), reused by the decode stage.
- One natural sub-module: if_id_reg. It is the IF/ID register with hold (stall), flush (bubble) and load controls.
- The FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset vector: M[0]=16'h0000, M[1]=16'h0020, rst 1 cycle → imem_addr 0, then 1, then 0x20. First valid IF/ID has if_id_pc=0x20 on the 3rd edge after rst deasserts.
- One-word stream: M[0x20..0x22]=16'h2001,16'h2002,16'h2003 → IF/ID valid on three consecutive cycles with pc 0x20, 0x21, 0x22 and matching instrs, imm=0.
- Two-word instruction: M[0x20]=16'hC123, M[0x21]=16'hBEEF → one bubble cycle, then instr=C123, imm=BEEF, pc=0x20, valid=1; next fetch at 0x22.
- Stall: hold load_use_case_enable=0 for 2 cycles mid-stream, including once in FETCH_IMM → imem_addr and IF/ID unchanged for both cycles. Sequence resumes with no loss or duplication.
- Redirect priority: in FETCH_IMM assert jmp_taken (target 0x40), ret_pc_valid (ret_pc 0x80) and stall together → next pc=0x80, IF/ID bubble, state FETCH, first word discarded.
- Wrap and mid-op reset: jump to 0xFFFFFFFF, then advance → pc wraps to 0. Assert rst in FETCH_IMM → outputs 0, vector fetch restarts at address 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and encodings for fetch and decode
//
// Purpose: fetch FSM state encoding, opcode field layout for the two-word
// test, NOP encoding and the IF/ID bundle type shared with decode.
// Ports: none (package).
package pipeline_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 16;

  // Opcode field position and the major opcode that marks a two-word instruction.
  localparam int unsigned OPC_MSB     = 15;
  localparam int unsigned OPC_LSB     = 13;
  localparam logic [2:0]  TWO_WORD_OP = 3'b110;

  localparam logic [INSTR_W_DEF-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_VEC_HI    = 2'd0,
    ST_VEC_LO    = 2'd1,
    ST_FETCH     = 2'd2,
    ST_FETCH_IMM = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [INSTR_W_DEF-1:0] imm;
    logic [PC_W_DEF-1:0]    pc;
    logic                   valid;
  } if_id_t;

  function automatic logic is_two_word(input logic [INSTR_W_DEF-1:0] word);
    return word[OPC_MSB:OPC_LSB] == TWO_WORD_OP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold, flush and load controls
//
// Purpose: holds the instruction handed from fetch to decode.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears to bubble)
//   flush_i         load a bubble (NOP, valid=0); wins over load_i
//   load_i          load instr_i/imm_i/pc_i with valid=1
//   (neither)       hold current contents
//   instr_o, imm_o, pc_o, valid_o  registered IF/ID contents
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [INSTR_W-1:0] imm_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] imm_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] imm_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= INSTR_W'(NOP);
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      imm_q   <= imm_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign imm_o   = imm_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, reset-vector load, one/two-word assembly
//
// Purpose: owns the PC, loads it from the reset vector, reads instruction
// memory and assembles one- or two-word instructions into IF/ID.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load_use_case_enable  0 = stall fetch and IF/ID, 1 = advance
//   jmp_taken/jmp_target  taken jump redirect
//   ret_pc_valid/ret_pc   stack-popped PC redirect (beats jump)
//   imem_addr/imem_data   combinational instruction-memory read
//   if_id_*               IF/ID register to decode (valid=0 is a bubble)
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned     PC_W           = 32,
  parameter int unsigned     INSTR_W        = 16,
  parameter logic [PC_W-1:0] RESET_VEC_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_use_case_enable,
  input  logic               jmp_taken,
  input  logic [PC_W-1:0]    jmp_target,
  input  logic               ret_pc_valid,
  input  logic [PC_W-1:0]    ret_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_imm,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] first_word_q, first_word_d;
  logic [PC_W-1:0]    first_pc_q, first_pc_d;

  logic               ifid_flush;
  logic               ifid_load;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic [INSTR_W-1:0] ifid_imm_d;
  logic [PC_W-1:0]    ifid_pc_d;

  logic               two_word;
  assign two_word = (imem_data[OPC_MSB:OPC_LSB] == TWO_WORD_OP);

  // Address depends only on registered state, never on inputs.
  always_comb begin
    case (state_q)
      ST_VEC_HI: imem_addr = RESET_VEC_ADDR;
      ST_VEC_LO: imem_addr = RESET_VEC_ADDR + PC_ONE;
      default:   imem_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_VEC_HI;
      pc_q         <= '0;
      first_word_q <= '0;
      first_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      first_word_q <= first_word_d;
      first_pc_q   <= first_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    first_word_d = first_word_q;
    first_pc_d   = first_pc_q;
    ifid_flush   = 1'b0;
    ifid_load    = 1'b0;
    ifid_instr_d = imem_data;
    ifid_imm_d   = '0;
    ifid_pc_d    = pc_q;

    case (state_q)
      // Vector states ignore stall and redirect; IF/ID is kept a bubble.
      ST_VEC_HI: begin
        pc_d[PC_W-1:PC_W-INSTR_W] = imem_data;
        state_d    = ST_VEC_LO;
        ifid_flush = 1'b1;
      end
      ST_VEC_LO: begin
        pc_d[INSTR_W-1:0] = imem_data;
        state_d    = ST_FETCH;
        ifid_flush = 1'b1;
      end
      default: begin
        if (ret_pc_valid) begin
          pc_d       = ret_pc;
          state_d    = ST_FETCH;
          ifid_flush = 1'b1;
        end else if (jmp_taken) begin
          pc_d       = jmp_target;
          state_d    = ST_FETCH;
          ifid_flush = 1'b1;
        end else if (load_use_case_enable) begin
          pc_d = pc_q + PC_ONE;
          if (state_q == ST_FETCH_IMM) begin
            ifid_load    = 1'b1;
            ifid_instr_d = first_word_q;
            ifid_imm_d   = imem_data;
            ifid_pc_d    = first_pc_q;
            state_d      = ST_FETCH;
          end else if (two_word) begin
            // Park the opcode word; the pair leaves together next cycle.
            first_word_d = imem_data;
            first_pc_d   = pc_q;
            ifid_flush   = 1'b1;
            state_d      = ST_FETCH_IMM;
          end else begin
            ifid_load = 1'b1;
          end
        end
        // else: stall, everything holds
      end
    endcase
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .instr_i (ifid_instr_d),
    .imm_i   (ifid_imm_d),
    .pc_i    (ifid_pc_d),
    .instr_o (if_id_instr),
    .imm_o   (if_id_imm),
    .pc_o    (if_id_pc),
    .valid_o (if_id_valid)
  );

endmodule
